// File: rtl/axis_hdr_pkg.sv
// Shared types and keep-mask helpers for the multi-beat header inserter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package axis_hdr_pkg;

  // Helpers work on a wide keep vector; callers zero-extend or truncate to their beat width.
  localparam int AXIS_MAX_BYTES = 128;
  typedef logic [AXIS_MAX_BYTES-1:0] keep_max_t;

  typedef enum logic [1:0] {IDLE, HDR, DATA, TAIL} state_e;

  function automatic int popcount(input keep_max_t keep);
    int cnt;
    cnt = 0;
    for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
      if (keep[i]) cnt++;
    end
    return cnt;
  endfunction

  // Low cnt bits set.
  function automatic keep_max_t lsb_keep(input int cnt);
    keep_max_t m;
    m = '0;
    for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
      m[i] = (i < cnt);
    end
    return m;
  endfunction

  // Top cnt bits of an nbytes-wide keep set.
  function automatic keep_max_t msb_keep(input int cnt, input int nbytes);
    keep_max_t m;
    m = '0;
    for (int i = 0; i < AXIS_MAX_BYTES; i++) begin
      m[i] = (i >= nbytes - cnt) && (i < nbytes);
    end
    return m;
  endfunction

  function automatic logic is_lsb_contig(input keep_max_t keep);
    return (keep != '0) && (keep == lsb_keep(popcount(keep)));
  endfunction

  function automatic logic is_msb_contig(input keep_max_t keep, input int nbytes);
    return (keep != '0) && (keep == msb_keep(popcount(keep), nbytes));
  endfunction

endpackage

// File: rtl/axis_hdr_shifter.sv
// Combinational byte repacker: {k residual bytes, top bytes of the beat}, plus new residual and spill count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the results are consumed.
module axis_hdr_shifter
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic [DATA_WD-1:0]      i_residual,
  input  logic [DATA_WD-1:0]      i_beat,
  input  logic [DATA_BYTE_WD-1:0] i_keep,
  input  logic [BYTE_CNT_WD-1:0]  i_k,
  output logic [DATA_WD-1:0]      o_out_word,
  output logic [DATA_WD-1:0]      o_new_residual,
  output logic [BYTE_CNT_WD-1:0]  o_overflow_cnt
);
  logic [DATA_WD-1:0] w_beat_m;
  int                 w_room;
  int                 w_m;

  // Drop bytes the keep marks invalid so padding always comes out as zero.
  always_comb begin
    w_beat_m = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (i_keep[i]) w_beat_m[8*i +: 8] = i_beat[8*i +: 8];
    end
  end

  assign w_room         = DATA_BYTE_WD - int'(i_k);
  assign w_m            = popcount(keep_max_t'(i_keep));
  // k = 0 degenerates to a straight pass of the beat (shift by full width yields zero).
  assign o_out_word     = (i_residual << (8 * w_room)) | (w_beat_m >> (8 * int'(i_k)));
  assign o_new_residual = (w_beat_m << (8 * w_room)) >> (8 * w_room);
  assign o_overflow_cnt = (w_m > w_room) ? BYTE_CNT_WD'(w_m - w_room) : '0;

endmodule

// File: rtl/axi_stream_insert_header_mb.sv
// Prepends a multi-beat header (first beat may be partial) to an AXI-Stream packet, dense output; AXIS_HDR_ERR_CHECK_EN adds err_keep.
// Latency: one registered output stage; sustains one output beat per clock.
// Backpressure: ready_in/ready_insert only when the output register can load; never both high.
module axi_stream_insert_header_mb
  import axis_hdr_pkg::*;
#(
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic                    last_insert,
  output logic                    ready_insert,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out
`ifdef AXIS_HDR_ERR_CHECK_EN
  ,
  output logic                    err_keep
`endif
);
  localparam logic [DATA_BYTE_WD-1:0] KEEP_ALL = '1;

  state_e                  r_state, w_state_nxt;
  logic                    r_init;
  logic                    r_valid, w_valid_nxt;
  logic [DATA_WD-1:0]      r_data, w_data_nxt;
  logic [DATA_BYTE_WD-1:0] r_keep, w_keep_nxt;
  logic                    r_last, w_last_nxt;
  logic [DATA_WD-1:0]      r_res, w_res_nxt;
  logic [BYTE_CNT_WD-1:0]  r_k, w_k_nxt;
  logic [BYTE_CNT_WD-1:0]  r_ovf, w_ovf_nxt;

  logic                    w_out_free, w_hs_ins, w_hs_in;
  int                      w_k_ins, w_m;
  logic [DATA_BYTE_WD-1:0] w_lsb_ins, w_msb_in, w_msb_last, w_msb_tail;
  logic [DATA_WD-1:0]      w_hdr_res, w_sh_beat, w_sh_out, w_sh_res;
  logic [DATA_BYTE_WD-1:0] w_sh_keep;
  logic [BYTE_CNT_WD-1:0]  w_sh_ovf;

  assign w_out_free   = !r_valid || ready_out;
  // r_init holds both readies low while reset is asserted and for the first cycle after.
  assign ready_insert = r_init && w_out_free && (r_state == IDLE || r_state == HDR);
  assign ready_in     = r_init && w_out_free && (r_state == DATA);
  assign w_hs_ins     = valid_insert && ready_insert;
  assign w_hs_in      = valid_in && ready_in;

  assign valid_out = r_valid;
  assign data_out  = r_data;
  assign keep_out  = r_keep;
  assign last_out  = r_last;

  assign w_k_ins    = popcount(keep_max_t'(keep_insert));
  assign w_m        = popcount(keep_max_t'(keep_in));
  assign w_lsb_ins  = DATA_BYTE_WD'(lsb_keep(w_k_ins));
  assign w_msb_in   = DATA_BYTE_WD'(msb_keep(w_m, DATA_BYTE_WD));
  assign w_msb_last = DATA_BYTE_WD'(msb_keep(int'(r_k) + w_m, DATA_BYTE_WD));
  assign w_msb_tail = DATA_BYTE_WD'(msb_keep(int'(r_ovf), DATA_BYTE_WD));

  // First header beat: keep only its low k bytes as the starting residual.
  always_comb begin
    w_hdr_res = '0;
    for (int i = 0; i < DATA_BYTE_WD; i++) begin
      if (w_lsb_ins[i]) w_hdr_res[8*i +: 8] = data_insert[8*i +: 8];
    end
  end

  axis_hdr_shifter #(
    .DATA_WD      (DATA_WD),
    .DATA_BYTE_WD (DATA_BYTE_WD),
    .BYTE_CNT_WD  (BYTE_CNT_WD)
  ) u_shifter (
    .i_residual     (r_res),
    .i_beat         (w_sh_beat),
    .i_keep         (w_sh_keep),
    .i_k            (r_k),
    .o_out_word     (w_sh_out),
    .o_new_residual (w_sh_res),
    .o_overflow_cnt (w_sh_ovf)
  );

  // Next state, output-register load and residual update. A full first header beat is stored
  // as k = 0 so that header and payload pass straight through and TAIL is never needed.
  always_comb begin
    w_state_nxt = r_state;
    w_valid_nxt = r_valid && !ready_out;
    w_data_nxt  = r_data;
    w_keep_nxt  = r_keep;
    w_last_nxt  = r_last;
    w_res_nxt   = r_res;
    w_k_nxt     = r_k;
    w_ovf_nxt   = r_ovf;
    w_sh_beat   = '0;
    w_sh_keep   = '0;
    case (r_state)
      IDLE: begin
        if (w_hs_ins) begin
          w_res_nxt   = w_hdr_res;
          w_k_nxt     = (w_k_ins >= DATA_BYTE_WD) ? '0 : BYTE_CNT_WD'(w_k_ins);
          if (w_k_ins >= DATA_BYTE_WD) begin
            w_valid_nxt = 1'b1;
            w_data_nxt  = data_insert;
            w_keep_nxt  = KEEP_ALL;
            w_last_nxt  = 1'b0;
          end
          w_state_nxt = last_insert ? DATA : HDR;
        end
      end
      HDR: begin
        w_sh_beat = data_insert;
        w_sh_keep = KEEP_ALL;
        if (w_hs_ins) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_sh_out;
          w_keep_nxt  = KEEP_ALL;
          w_last_nxt  = 1'b0;
          w_res_nxt   = w_sh_res;
          if (last_insert) w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_sh_beat = data_in;
        w_sh_keep = w_msb_in;
        if (w_hs_in) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_sh_out;
          w_res_nxt   = w_sh_res;
          if (!last_in) begin
            w_keep_nxt = KEEP_ALL;
            w_last_nxt = 1'b0;
          end else if (w_sh_ovf == '0) begin
            w_keep_nxt  = w_msb_last;
            w_last_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_keep_nxt  = KEEP_ALL;
            w_last_nxt  = 1'b0;
            w_ovf_nxt   = w_sh_ovf;
            w_state_nxt = TAIL;
          end
        end
      end
      TAIL: begin
        // Beat input is zero here, so the shifter yields the residual MSB-aligned and zero-padded.
        if (w_out_free) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = w_sh_out;
          w_keep_nxt  = w_msb_tail;
          w_last_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Output register, residual and per-packet byte counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_init  <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_keep  <= '0;
      r_last  <= 1'b0;
      r_res   <= '0;
      r_k     <= '0;
      r_ovf   <= '0;
    end else begin
      r_init  <= 1'b1;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_keep  <= w_keep_nxt;
      r_last  <= w_last_nxt;
      r_res   <= w_res_nxt;
      r_k     <= w_k_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

`ifdef AXIS_HDR_ERR_CHECK_EN
  logic r_err, w_err;

  // Classify keep on every accepted beat; data flow ignores the result.
  always_comb begin
    w_err = 1'b0;
    if (w_hs_ins && r_state == IDLE) w_err = !is_lsb_contig(keep_max_t'(keep_insert));
    else if (w_hs_ins)               w_err = (keep_insert != KEEP_ALL);
    else if (w_hs_in && !last_in)    w_err = (keep_in != KEEP_ALL);
    else if (w_hs_in)                w_err = !is_msb_contig(keep_max_t'(keep_in), DATA_BYTE_WD);
  end

  // One-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= w_err;
  end

  assign err_keep = r_err;
`endif

endmodule

// File: tb/tb_axi_stream_insert_header_mb.sv
// Self-checking bench for axi_stream_insert_header_mb at DATA_WD=32.
// Latency: n/a (testbench).
// Backpressure: ready_out is stalled in one scenario.
module tb_axi_stream_insert_header_mb;
  localparam int K_HDR = 0, K_PAY = 1, K_EXP = 2, K_WAIT = 3;

  typedef struct {
    int          kind;
    logic [31:0] dat;
    logic [3:0]  keep;
    logic        last;
  } row_t;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in, last_in, ready_in;
  logic [31:0] data_in;
  logic [3:0]  keep_in;
  logic        valid_insert, last_insert, ready_insert;
  logic [31:0] data_insert;
  logic [3:0]  keep_insert;
  logic        valid_out, last_out, ready_out;
  logic [31:0] data_out;
  logic [3:0]  keep_out;
`ifdef AXIS_HDR_ERR_CHECK_EN
  logic        err_keep;
`endif

  row_t tbl[$];
  exp_t sb[$];
  int   sc_lo[4], sc_hi[4];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  axi_stream_insert_header_mb #(.DATA_WD(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_in     (valid_in),
    .data_in      (data_in),
    .keep_in      (keep_in),
    .last_in      (last_in),
    .ready_in     (ready_in),
    .valid_insert (valid_insert),
    .data_insert  (data_insert),
    .keep_insert  (keep_insert),
    .last_insert  (last_insert),
    .ready_insert (ready_insert),
    .valid_out    (valid_out),
    .data_out     (data_out),
    .keep_out     (keep_out),
    .last_out     (last_out),
    .ready_out    (ready_out)
`ifdef AXIS_HDR_ERR_CHECK_EN
    ,
    .err_keep     (err_keep)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Output monitor: compares each accepted output beat with the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && valid_out === 1'b1 && ready_out === 1'b1) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_beat: got %h/%h/%b, expected no output", data_out, keep_out, last_out);
      end else begin
        e = sb.pop_front();
        check("out_beat", 64'({data_out, keep_out, last_out}), 64'(e));
      end
    end
  end

  function automatic void add(input int kind, input logic [31:0] d, input logic [3:0] k, input logic l);
    row_t r;
    r.kind = kind;
    r.dat  = d;
    r.keep = k;
    r.last = l;
    tbl.push_back(r);
  endfunction

  // Called at posedge+1; returns at posedge+1 right after the handshake edge.
  task automatic drive(input int kind, input logic [31:0] d, input logic [3:0] k, input logic l);
    bit done;
    done = 1'b0;
    if (kind == K_HDR) begin
      valid_insert = 1'b1; data_insert = d; keep_insert = k; last_insert = l;
    end else begin
      valid_in = 1'b1; data_in = d; keep_in = k; last_in = l;
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      done = (kind == K_HDR) ? ready_insert : ready_in;
      @(posedge clk);
      #1;
    end
    valid_insert = 1'b0;
    valid_in     = 1'b0;
    if (!done) check("handshake_timeout", 64'(done), 64'd1);
  endtask

  task automatic wait_drain();
    int c;
    c = 0;
    while (sb.size() != 0 && c < 300) begin
      @(negedge clk);
      c++;
    end
    check("drain", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      case (tbl[i].kind)
        K_EXP:   sb.push_back({tbl[i].dat, tbl[i].keep, tbl[i].last});
        K_WAIT:  wait_drain();
        default: drive(tbl[i].kind, tbl[i].dat, tbl[i].keep, tbl[i].last);
      endcase
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    valid_in = 1'b0; data_in = '0; keep_in = '0; last_in = 1'b0;
    valid_insert = 1'b0; data_insert = '0; keep_insert = '0; last_insert = 1'b0;
    ready_out = 1'b1;

    // Scenario 1: k=2, payload fits in the last beat.
    sc_lo[0] = tbl.size();
    add(K_EXP, 32'h11223344, 4'hF, 1'b0);
    add(K_EXP, 32'h55667788, 4'hF, 1'b1);
    add(K_HDR, 32'h00001122, 4'h3, 1'b1);
    add(K_PAY, 32'h33445566, 4'hF, 1'b0);
    add(K_PAY, 32'h778899AA, 4'hC, 1'b1);
    add(K_WAIT, 32'h0, 4'h0, 1'b0);
    sc_hi[0] = tbl.size() - 1;
    // Scenario 2: k=3, last beat spills into TAIL.
    sc_lo[1] = tbl.size();
    add(K_EXP, 32'h11223344, 4'hF, 1'b0);
    add(K_EXP, 32'h55667788, 4'hF, 1'b0);
    add(K_EXP, 32'h99000000, 4'h8, 1'b1);
    add(K_HDR, 32'h00112233, 4'h7, 1'b1);
    add(K_PAY, 32'h44556677, 4'hF, 1'b0);
    add(K_PAY, 32'h8899AABB, 4'hC, 1'b1);
    add(K_WAIT, 32'h0, 4'h0, 1'b0);
    sc_hi[1] = tbl.size() - 1;
    // Scenario 3: two header beats, k=1.
    sc_lo[2] = tbl.size();
    add(K_EXP, 32'hAABBCCDD, 4'hF, 1'b0);
    add(K_EXP, 32'hEE112233, 4'hF, 1'b0);
    add(K_EXP, 32'h44000000, 4'h8, 1'b1);
    add(K_HDR, 32'h000000AA, 4'h1, 1'b0);
    add(K_HDR, 32'hBBCCDDEE, 4'hF, 1'b1);
    add(K_PAY, 32'h11223344, 4'hF, 1'b1);
    add(K_WAIT, 32'h0, 4'h0, 1'b0);
    sc_hi[2] = tbl.size() - 1;
    // Scenario 4: full-width header, payload passes unchanged.
    sc_lo[3] = tbl.size();
    add(K_EXP, 32'hCAFEF00D, 4'hF, 1'b0);
    add(K_EXP, 32'h01020304, 4'hF, 1'b0);
    add(K_EXP, 32'h05060000, 4'hC, 1'b1);
    add(K_HDR, 32'hCAFEF00D, 4'hF, 1'b1);
    add(K_PAY, 32'h01020304, 4'hF, 1'b0);
    add(K_PAY, 32'h05060000, 4'hC, 1'b1);
    add(K_WAIT, 32'h0, 4'h0, 1'b0);
    sc_hi[3] = tbl.size() - 1;

    // Reset state.
    @(negedge clk);
    check("rst_valid_out",    64'(valid_out),    64'd0);
    check("rst_data_out",     64'(data_out),     64'd0);
    check("rst_keep_out",     64'(keep_out),     64'd0);
    check("rst_last_out",     64'(last_out),     64'd0);
    check("rst_ready_in",     64'(ready_in),     64'd0);
    check("rst_ready_insert", 64'(ready_insert), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int s = 0; s < 4; s++) run_rows(sc_lo[s], sc_hi[s]);

    // Scenario 2 with ready_out low for 3 cycles after the first output beat.
    fork
      run_rows(sc_lo[1], sc_hi[1]);
      begin
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
          @(negedge clk);
          seen = valid_out && ready_out;
        end
        check("stall_trigger", 64'(seen), 64'd1);
        @(posedge clk);
        #1 ready_out = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("stall_hold", 64'({valid_out, data_out, keep_out, last_out, ready_in}),
                64'({1'b1, 32'h55667788, 4'hF, 1'b0, 1'b0}));
        end
        @(posedge clk);
        #1 ready_out = 1'b1;
      end
    join

    // Reset during DATA: partial packet must vanish, outputs return to zero.
    drive(K_HDR, 32'h00001122, 4'h3, 1'b1);
    drive(K_PAY, 32'h33445566, 4'hF, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", 64'({valid_out, data_out, keep_out, last_out, ready_in, ready_insert}), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_rows(sc_lo[0], sc_hi[0]);

`ifdef AXIS_HDR_ERR_CHECK_EN
    begin
      int errs;
      errs = 0;
      sb.push_back({32'h11221122, 4'hF, 1'b1});
      drive(K_HDR, 32'h00001122, 4'h3, 1'b1);
      fork
        drive(K_PAY, 32'h11220000, 4'hA, 1'b1);
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          if (err_keep) errs++;
        end
      join
      check("err_keep_pulses", 64'(errs), 64'd1);
      wait_drain();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_stream_insert_header_mb.md
Name: axi_stream_insert_header_mb

Overview:
Parametrised successor to the single-beat header inserter. It prepends a multi-beat header stream to an AXI-Stream payload packet and repacks the bytes so the output is dense. Only the first header beat may be partial; it is LSB-aligned. It sits between the packet source and the egress AXI-Stream port. Sustained throughput is one output beat per clock.

Parameters:
DATA_WD, 32, data width in bits; multiple of 8, >=16
DATA_BYTE_WD, DATA_WD/8, bytes per beat
BYTE_CNT_WD, $clog2(DATA_BYTE_WD), width of byte counts

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
valid_in  in  1  payload valid
data_in  in  DATA_WD  payload data; byte 0 = MSB
keep_in  in  DATA_BYTE_WD  payload keep; all ones except on the last beat, where it is MSB-contiguous
last_in  in  1  payload last beat
ready_in  out  1  payload ready
valid_insert  in  1  header valid
data_insert  in  DATA_WD  header data
keep_insert  in  DATA_BYTE_WD  header keep; first beat LSB-contiguous and non-zero, later beats all ones
last_insert  in  1  last header beat
ready_insert  out  1  header ready
valid_out  out  1  output valid
data_out  out  DATA_WD  output data
keep_out  out  DATA_BYTE_WD  output keep; MSB-contiguous
last_out  out  1  output last
ready_out  in  1  output ready

Behaviour:
- Clock and reset are fixed: one clock, clk; rst_n is asynchronous and active-low.
- Reset values: valid_out=0, data_out=0, keep_out=0, last_out=0, ready_in=0, ready_insert=0; FSM=IDLE; residual cleared.
- Output register may load when out_free = !valid_out || ready_out.
- While valid_out && !ready_out, data_out, keep_out and last_out are held stable.
- k = popcount(first keep_insert), 1..DATA_BYTE_WD; k is fixed for the whole packet.
- Residual register holds k bytes.
- Each output beat = {residual k bytes, top DATA_BYTE_WD-k bytes of the accepted beat}; the new residual = low k bytes of that beat.
- FSM IDLE:
  - ready_insert = out_free.
  - On the first header handshake: capture residual and k; no output beat.
  - Go to DATA if last_insert, else HDR.
- FSM HDR:
  - ready_insert = out_free.
  - Each full header beat emits one full output beat (keep all ones).
  - On last_insert go to DATA.
- FSM DATA:
  - ready_in = out_free.
  - Non-last beat: emit a full beat.
  - Last beat with m = popcount(keep_in) valid bytes:
    - if m <= DATA_BYTE_WD-k, emit one last beat with k+m bytes; go to IDLE.
    - else emit a full non-last beat, store the leftover m-(DATA_BYTE_WD-k) bytes; go to TAIL.
- FSM TAIL:
  - ready_in = 0, ready_insert = 0.
  - When out_free, emit the leftover bytes MSB-aligned, zero-padded, last_out=1; go to IDLE.
- k = DATA_BYTE_WD: the header word passes as one full beat; payload passes unchanged; TAIL never entered.
- A new header is accepted only in IDLE. There is no overlap between packets.
- ready_in and ready_insert are never both high.
- Keep on ready does not depend combinationally on valid_in or valid_insert.
- Zero-padded bytes in data_out are driven 0.
- Reset asserted mid-packet: immediate return to reset values; the partial packet is dropped and never completed.

Optional Feature:
Macro AXIS_HDR_ERR_CHECK_EN.
- With the macro: adds output port err_keep (1 bit, reset 0). It pulses high for one cycle on the handshake of:
  - a first header beat with non-LSB-contiguous or zero keep_insert;
  - a later header beat with keep_insert not all ones;
  - a non-last payload beat with keep_in not all ones;
  - a last payload beat with zero or non-MSB-contiguous keep_in.
  Data flow is unaffected.
- Without the macro: the port is absent and keep is interpreted by popcount only.

Decomposition:
- Package axis_hdr_pkg holds:
  - FSM state enum (IDLE, HDR, DATA, TAIL);
  - function popcount(keep);
  - function msb_keep(count) returning an MSB-contiguous mask;
  - function lsb_keep(count);
  - contiguity-check functions.
- Sub-module axis_hdr_shifter: combinational concat/shift of residual and the incoming beat by k. Outputs out_word, new_residual, overflow_cnt.

Test Plan:
DATA_WD=32 for all scenarios.
- Header 0x00001122 keep 0011 last_insert; data 0x33445566 keep 1111, then 0x778899AA keep 1100 last -> out 0x11223344/1111, 0x55667788/1111 last.
- Header 0x00112233 keep 0111 last_insert; data 0x44556677, then 0x8899AABB keep 1100 last -> out 0x11223344, 0x55667788 non-last, 0x99000000 keep 1000 last via TAIL.
- Header 0x000000AA keep 0001, then 0xBBCCDDEE keep 1111 last_insert; data 0x11223344 keep 1111 last -> out 0xAABBCCDD, 0xEE112233, 0x44000000 keep 1000 last.
- Header keep 1111 0xCAFEF00D; data 0x01020304, then 0x05060000 keep 1100 last -> out 0xCAFEF00D, 0x01020304, 0x05060000 keep 1100 last.
- Scenario 2 with ready_out=0 for 3 cycles after the first output beat -> data_out held stable, ready_in=0, same three beats in order, none lost or duplicated.
- rst_n low for 1 cycle during DATA, then scenario 1 rerun -> all outputs 0 during reset; clean scenario-1 output afterwards. With AXIS_HDR_ERR_CHECK_EN: payload keep 1010 last -> err_keep pulses 1 cycle.
